// File: rtl/sym_vn_lut_banked.sv
// ---------------------------------------------------------------------------
// sym_vn_lut_banked
//
// Purpose:
//   Multi-port lookup table. The table is loaded once as a stream of
//   DEPTH entries, then read through PORT_NUM independent read ports.
//   Two read ports share one bank. Every bank holds an identical copy of
//   the table, so all ports can read any address in the same cycle
//   without arbitration.
//
// Ports:
//   write_clk      in   1                 sole clock, rising edge
//   rst            in   1                 asynchronous, active-high reset
//   load_start     in   1                 request to (re)load the table
//   lut_in         in   DATA_W            streamed table entry
//   lut_in_valid   in   1                 qualifies lut_in
//   lut_ready      out  1                 table complete and readable
//   load_done      out  1                 one-cycle pulse on first READY cycle
//   read_en        in   PORT_NUM          per-port read request
//   read_addr      in   PORT_NUM*ADDR_W   port k at [k*ADDR_W +: ADDR_W]
//   lut_data       out  PORT_NUM*DATA_W   port k at [k*DATA_W +: DATA_W]
//   lut_data_valid out  PORT_NUM          per-port read-data qualifier
// ---------------------------------------------------------------------------
module sym_vn_lut_banked #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 7,
    parameter int PORT_NUM = 4
) (
    input  logic                         write_clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic [DATA_W-1:0]            lut_in,
    input  logic                         lut_in_valid,
    output logic                         lut_ready,
    output logic                         load_done,
    input  logic [PORT_NUM-1:0]          read_en,
    input  logic [PORT_NUM*ADDR_W-1:0]   read_addr,
    output logic [PORT_NUM*DATA_W-1:0]   lut_data,
    output logic [PORT_NUM-1:0]          lut_data_valid
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int NUM_BANKS = PORT_NUM / 2;

    // Refuse to elaborate with an unusable port count or address width.
    generate
        if ((PORT_NUM % 2) != 0 || PORT_NUM < 2) begin : g_bad_port_num
            $error("sym_vn_lut_banked: PORT_NUM must be even and >= 2");
        end
        if (ADDR_W < 1 || ADDR_W > 10 || DATA_W < 1) begin : g_bad_width
            $error("sym_vn_lut_banked: ADDR_W must be 1..10 and DATA_W >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wptr;
    logic                r_lut_ready;
    logic                r_load_done;

    logic                w_we;
    logic                w_rd_ok;

    // Writes only happen while loading; reads only once the table is whole.
    assign w_we    = (r_state == LOAD) && lut_in_valid;
    assign w_rd_ok = (r_state == READY);

    // -----------------------------------------------------------------------
    // Load controller
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_wptr      <= '0;
            r_lut_ready <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                EMPTY: begin
                    if (load_start) begin
                        r_state <= LOAD;
                        r_wptr  <= '0;
                    end
                end
                LOAD: begin
                    // load_start is deliberately ignored here: a reload
                    // cannot restart a load that is already in progress.
                    if (lut_in_valid) begin
                        if (r_wptr == '1) begin
                            // Last entry written; the pointer is left at the
                            // top so a second pass can never begin.
                            r_state     <= READY;
                            r_lut_ready <= 1'b1;
                            r_load_done <= 1'b1;
                        end else begin
                            r_wptr <= r_wptr + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (load_start) begin
                        r_state     <= LOAD;
                        r_wptr      <= '0;
                        r_lut_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_lut_ready <= 1'b0;
                end
            endcase
        end
    end

    assign lut_ready = r_lut_ready;
    assign load_done = r_load_done;

    // -----------------------------------------------------------------------
    // Banks: one table copy per pair of read ports
    // -----------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] r_mem [DEPTH];

        // NOTE: table storage has no reset; its contents are only meaningful
        // after a complete load, and reads are gated until then.
        always_ff @(posedge write_clk) begin
            if (w_we) begin
                r_mem[r_wptr] <= lut_in;
            end
        end

        for (genvar p = 0; p < 2; p++) begin : g_port
            localparam int K = 2 * b + p;

            logic [DATA_W-1:0] r_rdata;
            logic              r_rvalid;

            // Read data holds its last value when no valid read occurs.
            always_ff @(posedge write_clk or posedge rst) begin
                if (rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_ok && read_en[K];
                    if (w_rd_ok && read_en[K]) begin
                        r_rdata <= r_mem[read_addr[K*ADDR_W +: ADDR_W]];
                    end
                end
            end

            assign lut_data[K*DATA_W +: DATA_W] = r_rdata;
            assign lut_data_valid[K]            = r_rvalid;
        end
    end

endmodule

// File: tb/tb_sym_vn_lut_banked.sv
// ---------------------------------------------------------------------------
// tb_sym_vn_lut_banked
//
// Purpose:
//   Directed, self-checking bench for sym_vn_lut_banked. Each cycle the
//   expected registered outputs are derived from a behavioural reference of
//   the table, pushed to a scoreboard queue, then popped and compared just
//   after the clock edge.
// ---------------------------------------------------------------------------
module tb_sym_vn_lut_banked;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 7;
    localparam int PORT_NUM = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    localparam int S_EMPTY = 0;
    localparam int S_LOAD  = 1;
    localparam int S_READY = 2;

    logic                        write_clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        load_start;
    logic [DATA_W-1:0]           lut_in;
    logic                        lut_in_valid;
    logic                        lut_ready;
    logic                        load_done;
    logic [PORT_NUM-1:0]         read_en;
    logic [PORT_NUM*ADDR_W-1:0]  read_addr;
    logic [PORT_NUM*DATA_W-1:0]  lut_data;
    logic [PORT_NUM-1:0]         lut_data_valid;

    sym_vn_lut_banked #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PORT_NUM (PORT_NUM)
    ) dut (
        .write_clk      (write_clk),
        .rst            (rst),
        .load_start     (load_start),
        .lut_in         (lut_in),
        .lut_in_valid   (lut_in_valid),
        .lut_ready      (lut_ready),
        .load_done      (load_done),
        .read_en        (read_en),
        .read_addr      (read_addr),
        .lut_data       (lut_data),
        .lut_data_valid (lut_data_valid)
    );

    always #5 write_clk = ~write_clk;

    typedef struct packed {
        logic                       ready;
        logic                       done;
        logic [PORT_NUM*DATA_W-1:0] data;
        logic [PORT_NUM-1:0]        valid;
    } exp_t;

    exp_t sb_q[$];

    // Reference state
    int                         m_state;
    int                         m_ptr;
    logic [DATA_W-1:0]          m_mem [DEPTH];
    logic                       m_ready;
    logic [PORT_NUM*DATA_W-1:0] m_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the outputs of this edge, push, clock, pop, compare.
    task automatic step();
        exp_t e;
        exp_t got;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (m_state == S_READY && read_en[k]) begin
                e.valid[k] = 1'b1;
                e.data[k*DATA_W +: DATA_W] = m_mem[read_addr[k*ADDR_W +: ADDR_W]];
            end else begin
                e.valid[k] = 1'b0;
                e.data[k*DATA_W +: DATA_W] = m_data[k*DATA_W +: DATA_W];
            end
        end
        e.ready = m_ready;
        e.done  = 1'b0;
        case (m_state)
            S_EMPTY: begin
                if (load_start) begin
                    m_state = S_LOAD;
                    m_ptr   = 0;
                end
            end
            S_LOAD: begin
                if (lut_in_valid) begin
                    m_mem[m_ptr] = lut_in;
                    if (m_ptr == DEPTH - 1) begin
                        m_state = S_READY;
                        e.ready = 1'b1;
                        e.done  = 1'b1;
                    end else begin
                        m_ptr++;
                    end
                end
            end
            default: begin
                if (load_start) begin
                    m_state = S_LOAD;
                    m_ptr   = 0;
                    e.ready = 1'b0;
                end
            end
        endcase
        m_ready = e.ready;
        m_data  = e.data;
        sb_q.push_back(e);

        @(posedge write_clk);
        #1;
        cyc++;
        if (load_done === 1'b1) n_done++;
        got = sb_q.pop_front();
        check($sformatf("c%0d lut_ready", cyc), 64'(lut_ready), 64'(got.ready));
        check($sformatf("c%0d load_done", cyc), 64'(load_done), 64'(got.done));
        check($sformatf("c%0d lut_data_valid", cyc), 64'(lut_data_valid), 64'(got.valid));
        check($sformatf("c%0d lut_data", cyc), 64'(lut_data), 64'(got.data));
    endtask

    task automatic rand_reads();
        read_en   = PORT_NUM'($urandom);
        read_addr = (PORT_NUM*ADDR_W)'($urandom);
    endtask

    // Stream n beats; mode 0: addr[3:0], 1: ~addr[3:0], 2: random.
    // With stall set, every beat is followed by an idle cycle.
    // load_start is pulsed together with beat ls_at (-1 for never).
    task automatic load_beats(input int n, input bit stall, input int mode, input int ls_at);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a            = 8'(i);
            lut_in_valid = 1'b1;
            case (mode)
                0:       lut_in = a[DATA_W-1:0];
                1:       lut_in = ~a[DATA_W-1:0];
                default: lut_in = DATA_W'($urandom);
            endcase
            load_start = (i == ls_at);
            read_en    = '1;
            read_addr  = (PORT_NUM*ADDR_W)'($urandom);
            step();
            load_start = 1'b0;
            if (stall) begin
                lut_in_valid = 1'b0;
                lut_in       = DATA_W'($urandom);
                step();
            end
        end
        lut_in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " lut_ready"}, 64'(lut_ready), 64'(0));
        check({tag, " load_done"}, 64'(load_done), 64'(0));
        check({tag, " lut_data"}, 64'(lut_data), 64'(0));
        check({tag, " lut_data_valid"}, 64'(lut_data_valid), 64'(0));
    endtask

    // Reset asserted between edges so its effect must be asynchronous.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        m_state = S_EMPTY;
        m_ptr   = 0;
        m_ready = 1'b0;
        m_data  = '0;
        @(posedge write_clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 10000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        load_start   = 1'b0;
        lut_in       = '0;
        lut_in_valid = 1'b0;
        read_en      = '0;
        read_addr    = '0;
        m_state      = S_EMPTY;
        m_ptr        = 0;
        m_ready      = 1'b0;
        m_data       = '0;

        // Power-on reset
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge write_clk);
        #1;
        rst = 1'b0;

        // Reads in EMPTY are blocked
        for (int i = 0; i < 3; i++) begin
            read_en   = '1;
            read_addr = (PORT_NUM*ADDR_W)'($urandom);
            step();
        end

        // Start load; lut_in_valid during the EMPTY cycle is ignored
        load_start   = 1'b1;
        lut_in_valid = 1'b1;
        lut_in       = 4'hA;
        step();
        load_start   = 1'b0;

        // Full continuous load with reads requested throughout
        load_beats(DEPTH, 1'b0, 0, -1);
        check("first load done pulses", 64'(n_done), 64'(1));

        // First READY cycle is over: load_done drops, lut_ready stays
        read_en = '0;
        step();

        // Parallel read, including a duplicate address
        read_en   = 4'b1111;
        read_addr = {7'd5, 7'd5, 7'd127, 7'd0};
        step();
        check("parallel lut_data", 64'(lut_data), 64'h55F0);
        check("parallel valid", 64'(lut_data_valid), 64'hF);

        // Random reads; stray lut_in_valid outside LOAD must not write
        for (int i = 0; i < 24; i++) begin
            rand_reads();
            lut_in_valid = 1'($urandom);
            lut_in       = DATA_W'($urandom);
            step();
        end
        lut_in_valid = 1'b0;

        // Reload from READY with a read in the same cycle
        read_en    = '1;
        read_addr  = (PORT_NUM*ADDR_W)'($urandom);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("reload lut_ready dropped", 64'(lut_ready), 64'(0));

        // Stalled load: one beat every other cycle
        load_beats(DEPTH, 1'b1, 1, -1);
        check("stalled load done pulses", 64'(n_done), 64'(2));

        for (int i = 0; i < 24; i++) begin
            rand_reads();
            step();
        end

        // Partial load interrupted by reset
        load_start = 1'b1;
        read_en    = '0;
        step();
        load_start = 1'b0;
        load_beats(60, 1'b0, 2, -1);
        do_reset("midload");
        for (int i = 0; i < 3; i++) begin
            read_en   = '1;
            read_addr = (PORT_NUM*ADDR_W)'($urandom);
            step();
        end

        // Fresh full load; load_start inside LOAD must not restart it
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_beats(DEPTH, 1'b0, 2, 10);
        check("third load done pulses", 64'(n_done), 64'(3));

        // All ports on one address, then random reads
        read_en   = '1;
        read_addr = {7'd77, 7'd77, 7'd77, 7'd77};
        step();
        for (int i = 0; i < 32; i++) begin
            rand_reads();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sym_vn_lut_banked.md
SYM_VN_LUT_BANKED -- requirements
Module: sym_vn_lut_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 4, width of one LUT entry.
REQ-002 SHALL have parameter ADDR_W, default 7, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter PORT_NUM, default 4, read-port count; even, >= 2.
REQ-004 SHALL have port write_clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_start  input  1  single-cycle request to (re)load the LUT.
REQ-007 SHALL have port lut_in  input  DATA_W  streamed LUT entry.
REQ-008 SHALL have port lut_in_valid  input  1  qualifies lut_in.
REQ-009 SHALL have port lut_ready  output  1  high while LUT contents are complete and readable.
REQ-010 SHALL have port load_done  output  1  one-cycle pulse at end of load.
REQ-011 SHALL have port read_en  input  PORT_NUM  per-port read request.
REQ-012 SHALL have port read_addr  input  PORT_NUM*ADDR_W  port k at bits [k*ADDR_W +: ADDR_W].
REQ-013 SHALL have port lut_data  output  PORT_NUM*DATA_W  port k at bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port lut_data_valid  output  PORT_NUM  per-port read-data qualifier.

Function
REQ-015 SHALL implement PORT_NUM/2 identical banks, DEPTH x DATA_W each; bank b serves ports 2b and 2b+1; every write goes to all banks.
REQ-016 SHALL implement FSM states EMPTY, LOAD, READY; EMPTY after reset.
REQ-017 SHALL move EMPTY->LOAD or READY->LOAD on load_start=1, clearing write pointer to 0; lut_ready drops the cycle after load_start accepted in READY.
REQ-018 SHALL ignore load_start while in LOAD.
REQ-019 SHALL, in LOAD with lut_in_valid=1, write lut_in at write pointer in all banks and increment pointer; lut_in_valid=0 stalls with no write.
REQ-020 SHALL ignore lut_in_valid outside LOAD.
REQ-021 SHALL, on the write to address DEPTH-1, enter READY next cycle; lut_ready=1 and load_done=1 for exactly that first READY cycle; pointer does not wrap into a second pass.
REQ-022 SHALL, in READY, with read_en[k]=1 at cycle t, present bank contents at read_addr port k on lut_data port k with lut_data_valid[k]=1 at t+1 (one-cycle registered latency).
REQ-023 SHALL allow all ports to read any addresses, including identical ones, in the same cycle with no stall.
REQ-024 SHALL drive lut_data_valid[k]=0 the cycle after read_en[k]=0 or any cycle when state was not READY; lut_data port k holds its last value then (never high-Z).
REQ-025 SHALL block reads during the final LOAD write cycle (state is still LOAD).
REQ-026 SHALL, on load_start in READY with read_en asserted same cycle, complete that read (valid at t+1) since state was READY at t.
REQ-027 SHALL tolerate ADDR_W 1..10, DATA_W >= 1; PORT_NUM odd is illegal (elaboration error).

Reset
REQ-028 SHALL, on rst=1 at any time, force state EMPTY, write pointer 0, lut_ready=0, load_done=0, lut_data=0, lut_data_valid=0, immediately (async).
REQ-029 SHALL not clear memory contents on reset; contents undefined until a full load completes.
REQ-030 SHALL, on reset mid-LOAD, discard partial load; lut_ready stays 0 until a fresh full load.

Verification
REQ-031 Full load: defaults, load_start, 128 beats lut_in=addr[3:0] continuous -> load_done and lut_ready at cycle after beat 127; nothing earlier.
REQ-032 Stalled load: lut_in_valid toggled 1/0 -> 128 writes over 256 cycles, contents correct, load_done single pulse.
REQ-033 Parallel read: READY, 4 ports read_en=1 addrs 0,127,5,5 -> next cycle lut_data = 0x0,0xF,0x5,0x5, valid=4'b1111.
REQ-034 Blocked read: read_en=4'b1111 in EMPTY and LOAD -> lut_data_valid=0, lut_data held at 0.
REQ-035 Reset mid-load: rst after 60 beats -> outputs 0, state EMPTY; reads invalid until new 128-beat load; load_start during LOAD ignored (no pointer reset).
REQ-036 Reload: load_start in READY with read_en=1 -> that read valid next cycle, lut_ready=0 next cycle, new contents readable after reload.
